sti_dac_sched: RTL and testbench
================================

# sti_dac_sched

Command scheduler that sequences the STI_DAC serial-transmit/DAC-write datapath. It accepts conversion commands from a host over a valid/ready interface and buffers them in a small FIFO. It issues each command to STI_DAC as a one-cycle `load` with stable `pi_*` fields, spacing loads to the transmitter's length-dependent busy time. On host request it drains the datapath, issues `pi_end`, and reports completion once STI_DAC raises `oem_finish`.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, 2–16).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  scheduler can accept a command.
- `cmd_data`  in  21  {length[20:19], fill[18], msb[17], low[16], data[15:0]}.
- `end_req`  in  1  host flush/end request (pulse or level).
- `done`  out  1  sequence complete; sticky until reset.
- `fifo_count`  out  $clog2(DEPTH)+1  buffered command count.
- `tx_count`  out  16  loads issued since reset, wraps at 65535→0.
- `load`  out  1  to STI_DAC, one-cycle pulse.
- `pi_data`  out  16  to STI_DAC.
- `pi_length`  out  2  to STI_DAC.
- `pi_fill`, `pi_msb`, `pi_low`  out  1 each  to STI_DAC.
- `pi_end`  out  1  to STI_DAC, one-cycle pulse.
- `oem_finish`  in  1  from STI_DAC, level.

## Operation
- States: IDLE, BUSY, DRAIN, END, WAIT_FIN, DONE.
- Push: `cmd_valid && cmd_ready`. `cmd_ready = (fifo_count < DEPTH) && !end_pending`. Simultaneous push and pop leaves the count unchanged.
- `end_pending` is set on any cycle with `end_req=1`. It clears only on reset. Once set, no further commands are accepted.
- IDLE, FIFO non-empty: pop the head. Register its fields onto `pi_*` and assert `load` for one cycle. Set the busy counter to N = 8*(length+1), i.e. 8/16/24/32. Increment `tx_count`. Go to BUSY.
- BUSY: decrement the counter each cycle. When it reaches 0, return to IDLE. The next load may issue in that same cycle.
- `pi_*` hold their last loaded values until the next load. STI_DAC samples `pi_data` throughout transmission, so these outputs must not change while BUSY.
- IDLE, FIFO empty, `end_pending`: go to DRAIN and hold it 3 cycles to flush the so_data/oem pipeline. Then go to END: `pi_end=1` for one cycle. Then go to WAIT_FIN.
- WAIT_FIN: remain until `oem_finish=1`, then go to DONE and set `done=1`.
- DONE: terminal until reset.
- Commands already in the FIFO when `end_req` arrives are all issued before DRAIN.

## Timing
- Reset values: `load=0`, `pi_end=0`, `pi_data=0`, `pi_length=0`, `pi_fill=pi_msb=pi_low=0`, `done=0`, `fifo_count=0`, `tx_count=0`, `cmd_ready=1`, state IDLE, `end_pending=0`.
- All outputs are registered except `cmd_ready`, which is combinational from registered state.
- Latency, empty FIFO: a push accepted at edge t produces `load=1` in cycle t+1.
- Spacing: a load in cycle t with length N means the next load is no earlier than cycle t+N+1. When the FIFO is non-empty, it occurs exactly at t+N+1.
- End sequence: last load at cycle t (length N), then DRAIN in cycles t+N+1..t+N+3, then `pi_end=1` in cycle t+N+4.
  - With no commands ever issued, `end_req` seen at edge t gives `pi_end` at t+4.
- `oem_finish` seen high at edge t gives `done=1` from cycle t+1.
- `oem_finish` is ignored in every state except WAIT_FIN.
- Full FIFO: `cmd_ready=0`, and `cmd_valid` is ignored with no overwrite.
- Reset mid-operation aborts immediately. The FIFO is emptied and `load`/`pi_end` drop asynchronously.

## Test plan
- Single command `cmd_data={2'b00,1'b0,1'b1,1'b0,16'hA5C3}` pushed at edge 10. Required: `load=1` in cycle 11 only, `pi_data=16'hA5C3`, `pi_msb=1`, and `pi_*` stable through cycle 19.
- Back-to-back commands with lengths 3, 0, 1. Required: loads at cycles t, t+33, t+42, and `tx_count=3`.
- Push 5 commands of length 3 while `DEPTH=4`. Required: `cmd_ready=0` when `fifo_count=4`, the 5th command is accepted only after the first pop, and no command is lost or duplicated.
- `end_req` asserted mid-transmission with 2 commands queued. Required: both commands load, further `cmd_valid` is refused, and `pi_end` pulses exactly 4 cycles after the last busy period ends. Drive `oem_finish=1` 50 cycles later; `done=1` follows on the next cycle.
- `end_req` with an empty FIFO straight after reset. Required: `pi_end` at +4 cycles and `load` never asserted.
- Assert `reset` during BUSY and during WAIT_FIN. Required: all outputs return to their reset values immediately, `fifo_count=0`, and the scheduler accepts new commands after reset is released.

Source files
------------

// File: rtl/sti_dac_sched_if.sv
// sti_dac_sched_if: host command / STI_DAC control bundle for the scheduler.
// Ports: cmd_valid/cmd_ready/cmd_data host push, end_req/done end handshake,
//        fifo_count/tx_count status, load/pi_*/pi_end/oem_finish to/from STI_DAC.
interface sti_dac_sched_if #(
  parameter int DEPTH = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [20:0]              cmd_data;
  logic                     end_req;
  logic                     done;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic [15:0]              tx_count;
  logic                     load;
  logic [15:0]              pi_data;
  logic [1:0]               pi_length;
  logic                     pi_fill;
  logic                     pi_msb;
  logic                     pi_low;
  logic                     pi_end;
  logic                     oem_finish;

  // Host / STI_DAC side: drives commands, end request and finish status.
  modport master (
    output cmd_valid, cmd_data, end_req, oem_finish,
    input  cmd_ready, done, fifo_count, tx_count,
    input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end
  );

  // Scheduler side.
  modport slave (
    input  cmd_valid, cmd_data, end_req, oem_finish,
    output cmd_ready, done, fifo_count, tx_count,
    output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end
  );
endinterface

// File: rtl/sti_dac_sched.sv
// sti_dac_sched: buffers host conversion commands and issues them to STI_DAC as
// one-cycle loads spaced by the transmit busy time (8*(length+1) cycles); on an
// end request it drains, pulses pi_end and reports done after oem_finish.
// Ports: clk, reset (async, active-high), bus (sti_dac_sched_if.slave).
module sti_dac_sched #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  sti_dac_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_DRAIN,
    S_END,
    S_WAIT_FIN,
    S_DONE
  } state_t;

  state_t        state, state_nxt;

  // Command FIFO storage and bookkeeping.
  logic [20:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [20:0]   head;
  logic          push, pop;

  logic          end_pending;
  logic [5:0]    busy_cnt, busy_cnt_nxt;
  logic [1:0]    drain_cnt, drain_cnt_nxt;
  logic          load_nxt, pi_end_nxt, done_nxt;

  assign head           = mem[rd_ptr];
  assign bus.cmd_ready  = (count < CW'(DEPTH)) && !end_pending;
  assign push           = bus.cmd_valid && bus.cmd_ready;
  assign bus.fifo_count = count;

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.cmd_data;
  end

  // ------------------------------------------------------ FSM next state
  always_comb begin
    state_nxt     = state;
    busy_cnt_nxt  = busy_cnt;
    drain_cnt_nxt = drain_cnt;
    pop           = 1'b0;
    load_nxt      = 1'b0;
    pi_end_nxt    = 1'b0;
    done_nxt      = bus.done;

    unique case (state)
      S_IDLE: begin
        // Queued commands always go out before the end sequence starts.
        if (count != '0) begin
          pop          = 1'b1;
          load_nxt     = 1'b1;
          busy_cnt_nxt = {1'b0, head[20:19], 3'b000} + 6'd8;
          state_nxt    = S_BUSY;
        end else if (end_pending) begin
          drain_cnt_nxt = 2'd2;
          state_nxt     = S_DRAIN;
        end
      end
      S_BUSY: begin
        // Load cycle plus N-1 BUSY cycles plus one IDLE cycle puts the next
        // load exactly N+1 cycles after the previous one.
        if (busy_cnt == 6'd1) begin
          state_nxt = S_IDLE;
        end else begin
          busy_cnt_nxt = busy_cnt - 6'd1;
        end
      end
      S_DRAIN: begin
        // Three cycles for the so_data/oem pipeline to empty.
        if (drain_cnt == 2'd0) begin
          pi_end_nxt = 1'b1;
          state_nxt  = S_END;
        end else begin
          drain_cnt_nxt = drain_cnt - 2'd1;
        end
      end
      S_END: begin
        state_nxt = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        if (bus.oem_finish) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------ FSM state and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      busy_cnt      <= '0;
      drain_cnt     <= '0;
      end_pending   <= 1'b0;
      bus.load      <= 1'b0;
      bus.pi_end    <= 1'b0;
      bus.done      <= 1'b0;
      bus.pi_data   <= '0;
      bus.pi_length <= '0;
      bus.pi_fill   <= 1'b0;
      bus.pi_msb    <= 1'b0;
      bus.pi_low    <= 1'b0;
      bus.tx_count  <= '0;
    end else begin
      state      <= state_nxt;
      busy_cnt   <= busy_cnt_nxt;
      drain_cnt  <= drain_cnt_nxt;
      bus.load   <= load_nxt;
      bus.pi_end <= pi_end_nxt;
      bus.done   <= done_nxt;
      if (bus.end_req) end_pending <= 1'b1;
      // pi_* only change on a pop, so they stay put for the whole busy time.
      if (pop) begin
        bus.pi_data   <= head[15:0];
        bus.pi_low    <= head[16];
        bus.pi_msb    <= head[17];
        bus.pi_fill   <= head[18];
        bus.pi_length <= head[20:19];
        bus.tx_count  <= bus.tx_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sti_dac_sched.sv
// tb_sti_dac_sched: directed scenarios plus randomized traffic for sti_dac_sched,
// checked every cycle against a timestamp/queue reference model, with literal
// expectations on load spacing, end timing, backpressure and reset behaviour.
module tb_sti_dac_sched;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sti_dac_sched_if #(.DEPTH(DEPTH)) bus ();

  sti_dac_sched #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ------------------------------------------------------ reference model
  // Commands wait in mq; a load may happen at a cycle no earlier than
  // next_ok (previous load cycle + N + 1). pend_at is the cycle of the
  // pi_end pulse once scheduled; fin_at is the cycle oem_finish was taken.
  logic [20:0] mq[$];
  int          next_ok = 0;
  int          pend_at = -1;
  int          fin_at  = -1;
  bit          m_pend  = 1'b0;
  logic        e_load = 1'b0, e_pi_end = 1'b0, e_done = 1'b0, e_ready = 1'b1;
  logic [20:0] e_pi  = '0;
  logic [15:0] e_tx  = '0;
  int          e_count = 0;

  initial forever begin
    int  pre;
    bit  rdy;
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      next_ok = 0; pend_at = -1; fin_at = -1; m_pend = 1'b0;
      e_load = 1'b0; e_pi_end = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      e_pi = '0; e_tx = '0; e_count = 0;
    end else begin
      cyc++;
      pre    = mq.size();
      rdy    = (pre < DEPTH) && !m_pend;
      e_load = 1'b0;
      if (pend_at < 0 && cyc >= next_ok) begin
        if (pre > 0) begin
          e_pi    = mq.pop_front();
          e_load  = 1'b1;
          e_tx    = e_tx + 16'd1;
          next_ok = cyc + 8 * (int'(e_pi[20:19]) + 1) + 1;
        end else if (m_pend) begin
          pend_at = cyc + 3;
        end
      end
      e_pi_end = (cyc == pend_at);
      // WAIT_FIN begins the cycle after the pi_end pulse.
      if (pend_at >= 0 && cyc >= pend_at + 2 && fin_at < 0 && bus.oem_finish)
        fin_at = cyc;
      e_done = (fin_at >= 0) && (cyc > fin_at);
      if (bus.cmd_valid && rdy) mq.push_back(bus.cmd_data);
      if (bus.end_req) m_pend = 1'b1;
      e_count = mq.size();
      e_ready = (mq.size() < DEPTH) && !m_pend;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // --------------------------------------------------------- compare
  int   load_cyc[$];
  int   pe_log[$];
  int   done_cyc  = -1;
  logic done_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (bus.load === 1'b1)   load_cyc.push_back(cyc);
    if (bus.pi_end === 1'b1) pe_log.push_back(cyc);
    if (bus.done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
    done_prev = bus.done;
    chk("load",       32'(bus.load),       32'(e_load));
    chk("pi_end",     32'(bus.pi_end),     32'(e_pi_end));
    chk("done",       32'(bus.done),       32'(e_done));
    chk("cmd_ready",  32'(bus.cmd_ready),  32'(e_ready));
    chk("fifo_count", 32'(bus.fifo_count), 32'(e_count));
    chk("tx_count",   32'(bus.tx_count),   32'(e_tx));
    chk("pi_data",    32'(bus.pi_data),    32'(e_pi[15:0]));
    chk("pi_low",     32'(bus.pi_low),     32'(e_pi[16]));
    chk("pi_msb",     32'(bus.pi_msb),     32'(e_pi[17]));
    chk("pi_fill",    32'(bus.pi_fill),    32'(e_pi[18]));
    chk("pi_length",  32'(bus.pi_length),  32'(e_pi[20:19]));
  end

  // --------------------------------------------------------- helpers
  function automatic logic [20:0] mk(input logic [1:0] len, input logic fill,
                                     input logic msb, input logic low,
                                     input logic [15:0] d);
    return {len, fill, msb, low, d};
  endfunction

  function automatic int lc_at(input int i);
    return (i < load_cyc.size()) ? load_cyc[i] : -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Synchronous assert/release at negedges; clears the event logs.
  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = '0;
    bus.end_req    = 1'b0;
    bus.oem_finish = 1'b0;
    cycles(2);
    load_cyc.delete();
    pe_log.delete();
    done_cyc  = -1;
    reset     = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [20:0] d, output int acc);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    while (bus.cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    acc = cyc;
    bus.cmd_valid = 1'b0;
    if (n >= 300) chk("push_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_pi_end(input int limit);
    int n;
    n = 0;
    while (pe_log.size() == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (pe_log.size() == 0) chk("pi_end_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------- stimulus
  initial begin
    int a, b, c, k, n;
    int acc[6];

    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = '0;
    bus.end_req    = 1'b0;
    bus.oem_finish = 1'b0;

    // Reset state.
    cycles(3);
    reset = 1'b0;
    cycles(1);
    chk("rst_ready", 32'(bus.cmd_ready), 32'(1));
    chk("rst_load",  32'(bus.load),      32'(0));
    chk("rst_count", 32'(bus.fifo_count), 32'(0));

    // Single command: load one cycle after acceptance, fields held N cycles.
    do_reset();
    cycles(7);
    push(mk(2'b00, 1'b0, 1'b1, 1'b0, 16'hA5C3), a);
    cycles(8);
    chk("t1_pi_data_hold", 32'(bus.pi_data), 32'(16'hA5C3));
    chk("t1_pi_msb_hold",  32'(bus.pi_msb),  32'(1));
    chk("t1_model_pi",     32'(e_pi),        32'(21'h02A5C3));
    cycles(4);
    chk("t1_load_count", 32'(load_cyc.size()), 32'(1));
    chk("t1_load_cycle", 32'(lc_at(0)), 32'(a + 1));

    // Back-to-back lengths 3, 0, 1: spacing 33 then 9.
    do_reset();
    push(mk(2'd3, 1'b1, 1'b0, 1'b1, 16'h1234), a);
    push(mk(2'd0, 1'b0, 1'b1, 1'b1, 16'hBEEF), b);
    push(mk(2'd1, 1'b1, 1'b1, 1'b0, 16'h0F0F), c);
    cycles(60);
    chk("t2_loads",  32'(load_cyc.size()), 32'(3));
    chk("t2_gap1",   32'(lc_at(1) - lc_at(0)), 32'(33));
    chk("t2_gap2",   32'(lc_at(2) - lc_at(1)), 32'(9));
    chk("t2_tx",     32'(bus.tx_count), 32'(3));
    chk("t2_model_tx", 32'(e_tx), 32'(3));

    // Full FIFO: first command loads at once, next four fill all entries,
    // the sixth must wait for the second pop.
    do_reset();
    for (int i = 0; i < 5; i++) push(mk(2'd3, 1'b0, 1'b0, 1'b0, 16'(16'hC000 + i)), acc[i]);
    chk("t3_full_count", 32'(bus.fifo_count), 32'(4));
    chk("t3_full_ready", 32'(bus.cmd_ready),  32'(0));
    push(mk(2'd3, 1'b0, 1'b0, 1'b0, 16'hC005), acc[5]);
    chk("t3_late_accept", 32'(acc[5]), 32'(lc_at(1) + 1));
    cycles(6 * 33 + 10);
    chk("t3_loads", 32'(load_cyc.size()), 32'(6));
    chk("t3_tx",    32'(bus.tx_count),    32'(6));

    // End request mid-transmission with two commands queued.
    do_reset();
    push(mk(2'd1, 1'b0, 1'b0, 1'b0, 16'h1111), a);
    push(mk(2'd0, 1'b1, 1'b0, 1'b0, 16'h2222), b);
    push(mk(2'd2, 1'b0, 1'b1, 1'b0, 16'h3333), c);
    cycles(3);
    bus.end_req = 1'b1;
    cycles(1);
    bus.end_req   = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = mk(2'd0, 1'b0, 1'b0, 1'b0, 16'hDEAD);
    cycles(20);
    chk("t4_refused", 32'(bus.cmd_ready), 32'(0));
    bus.cmd_valid = 1'b0;
    wait_pi_end(200);
    chk("t4_loads",   32'(load_cyc.size()), 32'(3));
    chk("t4_pi_end",  32'(pe_log.size() > 0 ? pe_log[0] : -1), 32'(lc_at(2) + 24 + 4));
    cycles(50);
    bus.oem_finish = 1'b1;
    k = cyc;
    cycles(1);
    chk("t4_done_not_yet", 32'(bus.done), 32'(0));
    cycles(1);
    chk("t4_done", 32'(bus.done), 32'(1));
    chk("t4_done_cycle", 32'(done_cyc), 32'(k + 2));
    bus.oem_finish = 1'b0;
    cycles(5);
    chk("t4_done_sticky", 32'(bus.done), 32'(1));

    // End request straight after reset.
    do_reset();
    bus.end_req = 1'b1;
    cycles(1);
    k = cyc;
    bus.end_req = 1'b0;
    wait_pi_end(20);
    chk("t5_pi_end", 32'(pe_log.size() > 0 ? pe_log[0] : -1), 32'(k + 4));
    cycles(5);
    chk("t5_no_load", 32'(load_cyc.size()), 32'(0));

    // Reset during a load/BUSY cycle with a command still queued.
    do_reset();
    push(mk(2'd3, 1'b1, 1'b1, 1'b1, 16'h5A5A), a);
    push(mk(2'd2, 1'b0, 1'b0, 1'b0, 16'h6B6B), b);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_load",  32'(bus.load),       32'(0));
    chk("t6_async_data",  32'(bus.pi_data),    32'(0));
    chk("t6_async_count", 32'(bus.fifo_count), 32'(0));
    chk("t6_async_tx",    32'(bus.tx_count),   32'(0));
    chk("t6_async_ready", 32'(bus.cmd_ready),  32'(1));
    cycles(2);
    load_cyc.delete();
    reset = 1'b0;
    push(mk(2'd0, 1'b0, 1'b0, 1'b1, 16'h7777), a);
    cycles(2);
    chk("t6_reload", 32'(lc_at(0)), 32'(a + 1));

    // Reset during WAIT_FIN.
    do_reset();
    bus.end_req = 1'b1;
    cycles(1);
    bus.end_req = 1'b0;
    wait_pi_end(20);
    cycles(5);
    #2 reset = 1'b1;
    #1;
    chk("t7_async_pi_end", 32'(bus.pi_end),    32'(0));
    chk("t7_async_done",   32'(bus.done),      32'(0));
    chk("t7_async_ready",  32'(bus.cmd_ready), 32'(1));
    cycles(2);
    load_cyc.delete();
    reset = 1'b0;
    push(mk(2'd1, 1'b1, 1'b0, 1'b0, 16'h8888), a);
    cycles(2);
    chk("t7_reload", 32'(lc_at(0)), 32'(a + 1));

    // Randomized traffic with stray oem_finish and a late end request.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid  = ($urandom_range(0, 1) == 1);
      bus.cmd_data   = 21'($urandom);
      bus.oem_finish = ($urandom_range(0, 3) == 0);
      bus.end_req    = (i == 300);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.end_req   = 1'b1;
    @(negedge clk);
    bus.end_req = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      bus.oem_finish = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) chk("rand_done_timeout", 32'(n), 32'(0));
    bus.oem_finish = 1'b0;
    cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
